// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - program-memory, redirect and decode-side bus of the fetch unit
//
// Purpose: groups every signal of instr_fetch_unit except clk/rst.
// master : the fetch unit (drives imem_addr and the instr_* head outputs)
// slave  : the environment (program memory, branch unit, decode stage)
// Signals:
//   imem_addr      fetch address to program memory (equals fetch PC)
//   imem_data      synchronous-read data for the address of the previous edge
//   redirect_valid take redirect_pc this cycle (flush + squash)
//   redirect_pc    new fetch target
//   instr_valid    FIFO head valid
//   instr_ready    decode accepts the head when instr_valid && instr_ready
//   instr_data     head instruction
//   instr_pc       PC of the head instruction
//   halted         fetch stopped on a halt opcode (only with FETCH_HALT_DETECT_EN)

interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              halted;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    input  instr_ready,
    output instr_data,
    output instr_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    output instr_ready,
    input  instr_data,
    input  instr_pc,
    input  halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - sequential instruction fetch with PC-tagged FIFO and redirect flush
//
// Purpose: drives the program memory's synchronous-read port with a running PC,
// captures the word one cycle later, buffers {pc, data} in a small FIFO and
// presents the head to decode with a valid/ready handshake. A redirect flushes
// the FIFO, drops any in-flight read and restarts fetch at redirect_pc.
// Ports:
//   clk  clock, all state updates on posedge
//   rst  synchronous active-high reset
//   bus  instr_fetch_unit_if.master (imem_*, redirect_*, instr_*, halted)
// Optional feature: define FETCH_HALT_DETECT_EN to stop fetching after a word
// whose top nibble is 4'hF is pushed; halted then reads 1 until redirect/rst.
// Without the macro halted is tied 0 and there is no HALT state.

module instr_fetch_unit #(
  parameter int                 ADDR_W     = 16,
  parameter int                 DATA_W     = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int                 FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
`else
  typedef enum logic {RUN = 1'b0} state_t;
`endif

  state_t state, state_nxt;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;

  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  // Last presented head, so instr_data/instr_pc hold their value while invalid.
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] hold_pc;

  logic              pop, push, halt_hit, issue;
  logic [CW:0]       occ;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    push      = 1'b0;
    halt_hit  = 1'b0;
    issue     = 1'b0;
    occ       = '0;

    pop  = (count != '0) && bus.instr_ready;
    // A redirect discards the response arriving this cycle.
    push = inflight && !bus.redirect_valid;
`ifdef FETCH_HALT_DETECT_EN
    halt_hit = push && (bus.imem_data[DATA_W-1 -: 4] == 4'hF);
`endif
    // Credit: everything already owed to the FIFO must fit after this pop.
    occ = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);

    case (state)
      RUN: begin
        issue = !bus.redirect_valid && !halt_hit && (occ < (CW+1)'(FIFO_DEPTH));
`ifdef FETCH_HALT_DETECT_EN
        if (halt_hit) state_nxt = HALT;
`endif
      end
      default: issue = 1'b0;
    endcase

    if (bus.redirect_valid) state_nxt = RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      hold_data   <= '0;
      hold_pc     <= '0;
    end else begin
      if (count != '0) begin
        hold_data <= fifo_data[rd_ptr];
        hold_pc   <= fifo_pc[rd_ptr];
      end
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_pc;
        inflight <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= fetch_pc;
          fetch_pc    <= fetch_pc + 1'b1;
        end
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_data[wr_ptr] <= bus.imem_data;
      fifo_pc[wr_ptr]   <= inflight_pc;
    end
  end

  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instr_data  = (count != '0) ? fifo_data[rd_ptr] : hold_data;
  assign bus.instr_pc    = (count != '0) ? fifo_pc[rd_ptr]   : hold_pc;
`ifdef FETCH_HALT_DETECT_EN
  assign bus.halted      = (state == HALT);
`else
  assign bus.halted      = 1'b0;
`endif

endmodule
